// File: rtl/tri_list_walker.sv
// Sequencer that walks a contiguous triangle index range through tri_reader and
// buffers returned blocks in a 2-entry FIFO. Optional perf counters: WALKER_PERF_EN.
module tri_list_walker #(
    parameter  int NDWORDS = 9,
    localparam int BLOCKSZ = 32 * NDWORDS
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [31:0]        first_idx,
    input  logic [31:0]        num_tris,
    output logic               busy,
    output logic               done,
    output logic [31:0]        rd_index,
    output logic               rd_read,
    input  logic               rd_iready,
    input  logic               rd_ovalid,
    input  logic [BLOCKSZ-1:0] rd_data,
    output logic               tri_valid,
    input  logic               tri_ready,
    output logic [BLOCKSZ-1:0] tri_data,
    output logic [31:0]        tri_index,
    output logic               tri_last
`ifdef WALKER_PERF_EN
    ,
    output logic [31:0]        perf_miss_cyc,
    output logic [31:0]        perf_stall_cyc
`endif
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARM   = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_ZERO  = 3'd4;

    typedef struct packed {
        logic [BLOCKSZ-1:0] data;
        logic [31:0]        idx;
        logic               last;
    } entry_t;

    logic [2:0]  state;
    logic [31:0] cur;
    logic [31:0] rem;

    entry_t      fifo_q [2];
    entry_t      head;
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;

    logic        start_acc;
    logic        push;
    logic        pop;

    assign start_acc = start && (state == S_IDLE);
    assign push      = (state == S_FETCH) && rd_ovalid;
    assign pop       = tri_valid && tri_ready;

    // ---------------- walk FSM ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            cur   <= '0;
            rem   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (num_tris != 32'd0) begin
                            cur   <= first_idx;
                            rem   <= num_tris;
                            state <= S_ARM;
                        end else begin
                            state <= S_ZERO;
                        end
                    end
                end
                S_ARM: begin
                    // Only one request in flight and a free slot guaranteed, so no overflow.
                    if ((count < 2'd2) && rd_iready)
                        state <= S_FETCH;
                end
                S_FETCH: begin
                    if (rd_ovalid) begin
                        if (rem == 32'd1) begin
                            state <= S_DRAIN;
                        end else begin
                            cur   <= cur + 32'd1;
                            rem   <= rem - 32'd1;
                            state <= S_ARM;
                        end
                    end
                end
                S_DRAIN: begin
                    if (pop && (count == 2'd1))
                        state <= S_IDLE;
                end
                S_ZERO:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy     = (state != S_IDLE);
    assign done     = (state == S_ZERO) || ((state == S_DRAIN) && pop && (count == 2'd1));
    assign rd_read  = (state == S_FETCH);
    assign rd_index = rd_read ? cur : 32'd0;

    // ---------------- 2-entry FIFO (no bypass) ----------------
    always_ff @(posedge clk) begin
        if (push)
            fifo_q[wr_ptr] <= '{data: rd_data, idx: cur, last: (rem == 32'd1)};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push)
                wr_ptr <= ~wr_ptr;
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; gating on valid keeps the outputs at 0 out of reset.
    assign head      = fifo_q[rd_ptr];
    assign tri_valid = (count != 2'd0);
    assign tri_data  = tri_valid ? head.data : '0;
    assign tri_index = tri_valid ? head.idx  : 32'd0;
    assign tri_last  = tri_valid && head.last;

`ifdef WALKER_PERF_EN
    // ---------------- saturating perf counters ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_miss_cyc  <= '0;
            perf_stall_cyc <= '0;
        end else if (start_acc) begin
            perf_miss_cyc  <= '0;
            perf_stall_cyc <= '0;
        end else begin
            if ((state == S_FETCH) && !rd_ovalid && (perf_miss_cyc != 32'hFFFF_FFFF))
                perf_miss_cyc <= perf_miss_cyc + 32'd1;
            if (tri_valid && !tri_ready && (perf_stall_cyc != 32'hFFFF_FFFF))
                perf_stall_cyc <= perf_stall_cyc + 32'd1;
        end
    end
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_tri_list_walker.sv
// Directed bench for tri_list_walker with a behavioural tri_reader responder.
module tb_tri_list_walker;

    localparam int BLK = 32 * 9;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           start = 1'b0;
    logic [31:0]    first_idx = '0;
    logic [31:0]    num_tris = '0;
    logic           busy, done;
    logic [31:0]    rd_index;
    logic           rd_read;
    logic           rd_iready = 1'b1;
    logic           rd_ovalid = 1'b0;
    logic [BLK-1:0] rd_data = '0;
    logic           tri_valid;
    logic           tri_ready = 1'b1;
    logic [BLK-1:0] tri_data;
    logic [31:0]    tri_index;
    logic           tri_last;

    tri_list_walker #(.NDWORDS(9)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .first_idx(first_idx),
        .num_tris(num_tris), .busy(busy), .done(done), .rd_index(rd_index),
        .rd_read(rd_read), .rd_iready(rd_iready), .rd_ovalid(rd_ovalid),
        .rd_data(rd_data), .tri_valid(tri_valid), .tri_ready(tri_ready),
        .tri_data(tri_data), .tri_index(tri_index), .tri_last(tri_last)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BLK-1:0] mk(input logic [31:0] idx);
        logic [BLK-1:0] r;
        for (int k = 0; k < 9; k++)
            r[k*32 +: 32] = idx ^ (32'h9E37_79B9 * 32'(k + 1));
        return r;
    endfunction

    // tri_reader model: answers rsp_delay cycles after read rises, one-cycle ovalid
    int rsp_delay = 1;
    int wcnt = 0;
    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            rd_ovalid = 1'b0;
            wcnt = 0;
        end else begin
            #1;
            if (rd_ovalid) rd_ovalid = 1'b0;
            else if (rd_read) begin
                if (wcnt >= rsp_delay) begin
                    rd_ovalid = 1'b1;
                    rd_data = mk(rd_index);
                    wcnt = 0;
                end else wcnt++;
            end
        end
    end

    // monitor, sampled mid-cycle
    logic [31:0]    issued[$];
    logic [31:0]    popped[$];
    logic           lastq[$];
    int rd_cyc, pushes, done_cnt, busy_cyc, bad_stab, bad_hold, bad_data, bad_done;
    logic           prv_rd = 0, prv_hold = 0, prv_done = 0, h_last;
    logic [31:0]    prv_idx, h_idx;
    logic [BLK-1:0] h_data;

    always @(negedge clk) begin
        if (!reset_n) begin
            prv_rd = 0; prv_hold = 0; prv_done = 0;
        end else begin
            if (rd_read) begin
                rd_cyc++;
                if (!prv_rd) issued.push_back(rd_index);
                else if (rd_index != prv_idx) bad_stab++;
            end
            if (rd_read && rd_ovalid) pushes++;
            if (prv_hold && (!tri_valid || tri_index != h_idx || tri_data != h_data || tri_last != h_last))
                bad_hold++;
            if (tri_valid && tri_ready) begin
                popped.push_back(tri_index);
                lastq.push_back(tri_last);
                if (tri_data != mk(tri_index)) bad_data++;
            end
            if (busy) busy_cyc++;
            if (done) begin
                done_cnt++;
                if (num_tris != 0 && !(tri_valid && tri_ready && tri_last)) bad_done++;
            end
            if (prv_done && busy) bad_done++;
            prv_rd = rd_read; prv_idx = rd_index; prv_done = done;
            prv_hold = tri_valid && !tri_ready;
            h_idx = tri_index; h_data = tri_data; h_last = tri_last;
        end
    end

    task automatic clr();
        issued.delete(); popped.delete(); lastq.delete();
        rd_cyc = 0; pushes = 0; done_cnt = 0; busy_cyc = 0;
        bad_stab = 0; bad_hold = 0; bad_data = 0; bad_done = 0;
    endtask

    task automatic kick(input logic [31:0] f, input logic [31:0] n);
        @(posedge clk); #1;
        first_idx = f; num_tris = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int i;
        for (i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done) break;
        end
        chk({tag, "_done_seen"}, (i < 3000), 1);
        @(posedge clk); #2;
    endtask

    task automatic chk_q(input string tag, input logic [31:0] q[$], input logic [31:0] f, input int n);
        chk({tag, "_len"}, q.size(), n);
        for (int k = 0; k < n; k++)
            chk(tag, (k < q.size()) ? q[k] : 32'hDEAD_BEEF, 32'(f + 32'(k)));
    endtask

    task automatic chk_clean(input string tag);
        chk({tag, "_stab"}, bad_stab, 0);
        chk({tag, "_hold"}, bad_hold, 0);
        chk({tag, "_data"}, bad_data, 0);
        chk({tag, "_done_ok"}, bad_done, 0);
        chk({tag, "_done_cnt"}, done_cnt, 1);
    endtask

    initial begin
        logic v0, v1, v2;
        int i;
        clr();
        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_read", rd_read, 0);
        chk("rst_rd_index", rd_index, 0);
        chk("rst_tri_valid", tri_valid, 0);
        chk("rst_tri_last", tri_last, 0);
        @(posedge clk); #1 reset_n = 1'b1;

        // 1: basic walk 5..7
        rsp_delay = 1; clr();
        kick(32'd5, 32'd3);
        wait_done("t1");
        chk_q("t1_issued", issued, 32'd5, 3);
        chk_q("t1_popped", popped, 32'd5, 3);
        chk("t1_last", {lastq[0], lastq[1], lastq[2]}, 3'b001);
        chk_clean("t1");
        chk("t1_idle", busy, 0);

        // 2: empty walk
        clr();
        kick(32'd9, 32'd0);
        wait_done("t2");
        chk("t2_busy_cyc", busy_cyc, 1);
        chk("t2_done_cnt", done_cnt, 1);
        chk("t2_no_read", issued.size(), 0);
        chk("t2_done_ok", bad_done, 0);
        chk("t2_idle", busy, 0);

        // 3: slow response
        rsp_delay = 20; clr();
        kick(32'd40, 32'd1);
        wait_done("t3");
        chk("t3_rd_cyc", rd_cyc, 21);
        chk("t3_pushes", pushes, 1);
        chk_q("t3_popped", popped, 32'd40, 1);
        chk_clean("t3");

        // 4: backpressure
        rsp_delay = 1; tri_ready = 1'b0; clr();
        kick(32'd0, 32'd4);
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("t4_rd_read_stalled", rd_read, 0);
        chk("t4_issued_stalled", issued.size(), 2);
        chk("t4_pushes_stalled", pushes, 2);
        chk("t4_head_valid", tri_valid, 1);
        chk("t4_head_idx", tri_index, 0);
        @(posedge clk); #1 tri_ready = 1'b1;
        wait_done("t4");
        chk_q("t4_issued", issued, 32'd0, 4);
        chk_q("t4_popped", popped, 32'd0, 4);
        chk("t4_last", {lastq[0], lastq[1], lastq[2], lastq[3]}, 4'b0001);
        chk_clean("t4");

        // 5: index wrap plus first-triangle latency with hit responses
        rsp_delay = 0; clr();
        kick(32'hFFFF_FFFF, 32'd2);
        @(negedge clk); v0 = tri_valid;
        @(negedge clk); v1 = tri_valid;
        @(negedge clk); v2 = tri_valid;
        chk("t5_latency", {v0, v1, v2}, 3'b001);
        wait_done("t5");
        chk_q("t5_issued", issued, 32'hFFFF_FFFF, 2);
        chk_q("t5_popped", popped, 32'hFFFF_FFFF, 2);
        chk("t5_last", {lastq[0], lastq[1]}, 2'b01);
        chk_clean("t5");

        // 6: async reset during FETCH, then fresh walk
        rsp_delay = 10; clr();
        kick(32'd100, 32'd5);
        for (i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rd_read) break;
        end
        chk("t6_fetch_seen", (i < 50), 1);
        repeat (3) @(negedge clk);
        chk("t6_pre_busy", busy, 1);
        chk("t6_pre_read", rd_read, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_read", rd_read, 0);
        chk("t6_rst_valid", tri_valid, 0);
        chk("t6_rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        rsp_delay = 1; clr();
        kick(32'd200, 32'd1);
        wait_done("t6");
        chk_q("t6_issued", issued, 32'd200, 1);
        chk_q("t6_popped", popped, 32'd200, 1);
        chk_clean("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
